// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
//
// Drain stage for a standard-mode (non-FWFT) FIFO. It issues reads against the
// FIFO's empty/dout pair, where data arrives one cycle after the read strobe.
// Captured words go into a 2-entry prefetch buffer (shift form: entry 0 is
// always the head). The buffer is presented as a valid/ready stream at full
// throughput. A beat counter frames the stream into BURST_LEN-beat bursts.
//
// Parameters
//   DSIZE      data width, equal to the FIFO's data width
//   BURST_LEN  beats per burst (>= 1); m_last marks every BURST_LEN-th beat
//
// Ports
//   clk         read-side clock
//   rst         synchronous active-high reset
//   fifo_dout   FIFO read data, valid the cycle after an accepted read
//   fifo_empty  FIFO empty flag
//   fifo_rd_en  FIFO read strobe (combinational, includes m_ready)
//   m_data      stream data (buffer head)
//   m_valid     stream valid
//   m_last      last beat of the current burst, qualified by m_valid
//   m_ready     stream ready from the consumer
//   burst_cnt   index of the current beat within the burst
// -----------------------------------------------------------------------------
module fifo_stream_reader #(
    parameter int DSIZE     = 8,
    parameter int BURST_LEN = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DSIZE-1:0]             fifo_dout,
    input  logic                         fifo_empty,
    output logic                         fifo_rd_en,
    output logic [DSIZE-1:0]             m_data,
    output logic                         m_valid,
    output logic                         m_last,
    input  logic                         m_ready,
    output logic [$clog2(BURST_LEN):0]   burst_cnt
);

    localparam int               CNT_W     = $clog2(BURST_LEN) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    // Prefetch buffer, entry 0 is the head.
    logic [DSIZE-1:0] buf_reg  [2];
    logic [DSIZE-1:0] buf_next [2];

    logic [1:0]       occ_reg;
    logic [1:0]       occ_next;
    logic             pend_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    logic             pop;
    logic [1:0]       occ_after_pop;
    logic [1:0]       inflight;

    assign m_valid       = (occ_reg != 2'd0);
    assign pop           = m_valid & m_ready;

    // Words held or on their way: buffered plus the one read last cycle.
    // Never exceeds 2, so 2 bits suffice.
    assign inflight      = occ_reg + {1'b0, pend_reg};
    assign occ_after_pop = occ_reg - {1'b0, pop};
    assign occ_next      = occ_after_pop + {1'b0, pend_reg};

    // A read is only issued when the slot it will land in is guaranteed free
    // once this cycle's pop is accounted for; that keeps inflight <= 2 while
    // still sustaining one read per cycle when the consumer is ready.
    assign fifo_rd_en    = !rst && !fifo_empty && ((inflight - {1'b0, pop}) < 2'd2);

    // Per-entry next value: shift towards the head on pop, then drop the
    // captured word into the first free slot after that shift.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            localparam int SRC = (gi < 1) ? gi + 1 : gi;
            logic [DSIZE-1:0] shifted;

            assign shifted      = pop ? buf_reg[SRC] : buf_reg[gi];
            assign buf_next[gi] = (pend_reg && (occ_after_pop == 2'(gi))) ? fifo_dout : shifted;
        end
    endgenerate

    always_comb begin
        cnt_next = cnt_reg;
        if (pop) begin
            cnt_next = (cnt_reg == LAST_BEAT) ? '0 : cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                buf_reg[i] <= '0;
            end
            occ_reg  <= 2'd0;
            pend_reg <= 1'b0;
            cnt_reg  <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                buf_reg[i] <= buf_next[i];
            end
            occ_reg  <= occ_next;
            pend_reg <= fifo_rd_en;
            cnt_reg  <= cnt_next;
        end
    end

    assign m_data    = buf_reg[0];
    assign m_last    = m_valid && (cnt_reg == LAST_BEAT);
    assign burst_cnt = cnt_reg;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_stream_reader
//
// Stimulus loads words into a small standard-mode FIFO model and pushes the
// expected beats (data, last, beat index) into a scoreboard queue. A monitor
// on the falling edge pops and compares every accepted beat, and also checks
// the stream rules (stall stability, no read while empty, occupancy bound).
// -----------------------------------------------------------------------------
module tb_fifo_stream_reader;

    localparam int DSIZE     = 8;
    localparam int BURST_LEN = 16;
    localparam int CNT_W     = $clog2(BURST_LEN) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [DSIZE-1:0] fifo_dout = '0;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [DSIZE-1:0] m_data;
    logic             m_valid;
    logic             m_last;
    logic             m_ready = 1'b0;
    logic [CNT_W-1:0] burst_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .DSIZE     (DSIZE),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .burst_cnt  (burst_cnt)
    );

    // ---------------- FIFO model (standard read mode) ----------------
    logic [DSIZE-1:0] fifo_mem [0:1023];
    int               wr_ptr   = 0;   // written by stimulus only
    int               rd_ptr   = 0;   // written by the model only
    logic             fifo_clr = 1'b0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_clr) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en) begin
            fifo_dout <= fifo_mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [DSIZE-1:0] data;
        logic             last;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    int               infl = 0;       // model of buffered + in-flight words
    logic             prev_stall = 1'b0;
    logic [DSIZE-1:0] prev_data  = '0;
    logic             prev_last  = 1'b0;
    logic [CNT_W-1:0] prev_cnt   = '0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            infl       = 0;
            prev_stall = 1'b0;
        end else begin
            check("rd_en_while_empty", 32'(fifo_rd_en & fifo_empty), 32'd0);
            check("occ_pend_le_2", 32'(infl <= 2), 32'd1);
            if (prev_stall) begin
                check("stall_valid", 32'(m_valid), 32'd1);
                check("stall_data", 32'(m_data), 32'(prev_data));
                check("stall_last", 32'(m_last), 32'(prev_last));
                check("stall_cnt", 32'(burst_cnt), 32'(prev_cnt));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=0x%0h required=no_beat t=%0t", m_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", 32'(m_data), 32'(e.data));
                    check("beat_last", 32'(m_last), 32'(e.last));
                    check("beat_cnt", 32'(burst_cnt), 32'(e.cnt));
                    $display("beat data=0x%02h last=%0d cnt=%0d t=%0t", m_data, m_last, burst_cnt, $time);
                end
            end
            infl       = infl + int'(fifo_rd_en) - int'(m_valid && m_ready);
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            prev_cnt   = burst_cnt;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fifo_push(input logic [DSIZE-1:0] d);
        fifo_mem[wr_ptr] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic exp_push(input logic [DSIZE-1:0] d, input int idx);
        exp_t e;
        e.data = d;
        e.last = ((idx % BURST_LEN) == BURST_LEN - 1);
        e.cnt  = CNT_W'(idx % BURST_LEN);
        exp_q.push_back(e);
    endtask

    task automatic push(input logic [DSIZE-1:0] d, input int idx);
        fifo_push(d);
        exp_push(d, idx);
    endtask

    // Reset for n cycles starting in the current cycle; optionally flush the
    // FIFO model as the system would.
    task automatic do_reset(input int n, input logic clr);
        rst      = 1'b1;
        fifo_clr = clr;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("rd_en_in_reset", 32'(fifo_rd_en), 32'd0);
            tick();
        end
        rst      = 1'b0;
        fifo_clr = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            tick();
            c++;
        end
        check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
        tick();
        tick();
        @(negedge clk);
        check({name, "_idle_valid"}, 32'(m_valid), 32'd0);
        tick();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int sent;
        int cyc;

        tick();

        // Reset held 3 cycles with the FIFO non-empty.
        m_ready = 1'b1;
        fifo_push(8'h11);
        fifo_push(8'h22);
        fifo_push(8'h33);
        do_reset(3, 1'b0);
        exp_push(8'h11, 0);
        exp_push(8'h22, 1);
        exp_push(8'h33, 2);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c < 2) begin
                check("post_reset_valid", 32'(m_valid), 32'd0);
                check("post_reset_data", 32'(m_data), 32'd0);
                check("post_reset_last", 32'(m_last), 32'd0);
                check("post_reset_cnt", 32'(burst_cnt), 32'd0);
            end else begin
                check("first_valid", 32'(m_valid), 32'd1);
            end
            tick();
        end
        wait_drain("reset", 50);

        // Single word.
        do_reset(1, 1'b1);
        push(8'hA5, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("single_rd_en", 32'(fifo_rd_en), 32'(c == 0));
            check("single_valid", 32'(m_valid), 32'(c == 2));
            tick();
        end
        wait_drain("single", 50);

        // Throughput and framing: 64 words, contiguous from cycle 2 to 65.
        do_reset(1, 1'b1);
        for (int i = 0; i < 64; i++) begin
            push(8'(i), i);
        end
        for (int c = 0; c < 67; c++) begin
            @(negedge clk);
            check("thru_valid", 32'(m_valid), 32'(c >= 2 && c <= 65));
            tick();
        end
        wait_drain("thru", 50);

        // Backpressure: random ready, words trickle into the FIFO.
        do_reset(1, 1'b1);
        sent = 0;
        cyc  = 0;
        while ((sent < 256 || exp_q.size() != 0) && cyc < 5000) begin
            m_ready = 1'($urandom_range(0, 1));
            if (sent < 256 && $urandom_range(0, 1) == 1) begin
                push(8'(sent) ^ 8'h5A, sent);
                sent++;
            end
            tick();
            cyc++;
        end
        check("bp_all_sent", 32'(sent), 32'd256);
        m_ready = 1'b1;
        wait_drain("bp", 100);

        // Empty boundary: 5 words, refill 10 cycles after the FIFO empties.
        do_reset(1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            push(8'hB0 + 8'(i), i);
        end
        for (int c = 0; c < 21; c++) begin
            if (c == 15) begin
                for (int i = 5; i < 8; i++) begin
                    push(8'hB0 + 8'(i), i);
                end
            end
            @(negedge clk);
            if (c == 7 || c == 16) begin
                check("empty_gap_valid", 32'(m_valid), 32'd0);
            end
            if (c == 17) begin
                check("refill_valid", 32'(m_valid), 32'd1);
                check("refill_data", 32'(m_data), 32'hB5);
                check("refill_cnt", 32'(burst_cnt), 32'd5);
            end
            tick();
        end
        wait_drain("empty", 50);

        // Reset mid-burst at beat 7 with a read in flight.
        do_reset(1, 1'b1);
        for (int i = 0; i < 40; i++) begin
            fifo_push(8'h40 + 8'(i));
        end
        for (int i = 0; i < 7; i++) begin
            exp_push(8'h40 + 8'(i), i);
        end
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c == 8) begin
                check("mid_rd_before_reset", 32'(fifo_rd_en), 32'd1);
            end
            tick();
        end
        check("mid_beats_before_reset", 32'(exp_q.size()), 32'd0);
        do_reset(1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            push(8'h80 + 8'(i), i);
        end
        @(negedge clk);
        check("mid_post_valid", 32'(m_valid), 32'd0);
        check("mid_post_cnt", 32'(burst_cnt), 32'd0);
        tick();
        wait_drain("mid", 60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Downstream drain stage for `fifo_async` in standard (non-FWFT) read mode. It sits in the read-clock domain and issues `rd_en` against the FIFO's `empty`/`dout` pair, whose data arrives one cycle after the read. The read data passes through a 2-entry prefetch buffer and leaves as a valid/ready stream at full throughput. A beat counter frames the stream into fixed-length bursts with `m_last`.

## Interface
- `DSIZE`, 8: data width; must equal the FIFO's `DSIZE`.
- `BURST_LEN`, 16: beats per burst, ≥1; `m_last` marks every `BURST_LEN`-th accepted beat.
- `clk`  in  1  read-side clock (the FIFO's `rd_clk`).
- `rst`  in  1  reset; synchronous, active-high.
- `fifo_dout`  in  DSIZE  FIFO read data, valid the cycle after an accepted read.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd_en`  out  1  FIFO read strobe; combinational.
- `m_data`  out  DSIZE  stream data.
- `m_valid`  out  1  stream valid.
- `m_last`  out  1  last beat of burst; qualified by `m_valid`.
- `m_ready`  in  1  stream ready from the consumer.
- `burst_cnt`  out  clog2(BURST_LEN)+1  index of the current beat within the burst, 0..BURST_LEN-1.

## Operation
- **State**
  - 2-entry buffer: registers plus a head pointer, or shift form.
  - `occ` (0..2): buffer occupancy.
  - `pend` (0/1): a read was issued last cycle and its data has not yet been captured.
  - Beat counter `burst_cnt`.
- **Pop:** `pop = m_valid & m_ready`.
- **Read issue:** `fifo_rd_en = !rst & !fifo_empty & (occ + pend - pop < 2)`.
  - This path is combinational from `m_ready`.
  - `fifo_rd_en` is never high while `fifo_empty` = 1.
  - `occ + pend` never exceeds 2.
- **Capture:** when `pend` = 1, `fifo_dout` is written into the buffer tail that cycle. `pend` next = `fifo_rd_en`.
- **Output:**
  - `m_valid = (occ != 0)`.
  - `m_data` = buffer head.
  - Simultaneous capture and pop: the head advances, the new word goes to the tail, and `occ` is unchanged.
- **Framing:**
  - `m_last = m_valid & (burst_cnt == BURST_LEN-1)`.
  - On `pop`, `burst_cnt` increments and wraps from BURST_LEN-1 to 0.
  - BURST_LEN = 1: `m_last` equals `m_valid`.
- **Stream rules:**
  - While `m_valid & !m_ready`, `m_data`, `m_last` and `burst_cnt` hold stable.
  - `m_valid` never falls without a pop.
  - Word order is strictly FIFO order. No duplication, no loss.
- **Reset values:**
  - `m_valid` = 0, `m_last` = 0, `m_data` = 0, `burst_cnt` = 0, `fifo_rd_en` = 0.
  - Internally `occ` = 0 and `pend` = 0.
- **Reset mid-operation:** buffer contents and any in-flight word are discarded, and the burst restarts at beat 0. The system resets the FIFO together with this block, so discarded words are not meaningful.

## Timing
- **First word latency:** `fifo_empty` falls in cycle T with the buffer empty.
  - `fifo_rd_en` = 1 in T.
  - `fifo_dout` is captured at the end of T+1.
  - `m_valid` = 1 in T+2, with `m_data` = that word.
- **Steady state:** with `m_ready` held high and the FIFO non-empty, one beat per cycle with no bubbles (`occ` = 1, `pend` = 1, read plus pop every cycle).
- **Backpressure:** with `m_ready` low, at most 2 reads occur after the stall begins before `fifo_rd_en` stops. Reads resume in the same cycle that `m_ready` rises.
- **FIFO goes empty:** `fifo_rd_en` drops that cycle. `m_valid` stays high until the buffered words drain, then falls in the cycle after the last pop.
- **Reset:** `rst` high in cycle R gives all outputs at reset values from R+1. `fifo_rd_en` is forced low during R.

## Test plan
- **Reset:** hold `rst` for 3 cycles with `fifo_empty` = 0 → `fifo_rd_en` = 0 throughout. After release, all outputs equal the reset values until the first read completes.
- **Single word:** FIFO model holds 0xA5, `m_ready` = 1, and `fifo_empty` falls in cycle 0 → `fifo_rd_en` = 1 in cycle 0 only. `m_valid` = 1 with `m_data` = 0xA5 in cycle 2 only, and `m_last` = 0 there (`burst_cnt` = 0).
- **Throughput and framing:** BURST_LEN = 16, 64 words 0x00..0x3F, `m_ready` = 1 → outputs are contiguous from cycle 2 to cycle 65 in order. `m_last` is high exactly on 0x0F, 0x1F, 0x2F and 0x3F.
- **Backpressure:** random `m_ready` (50%) over 256 words → order intact, no loss. `fifo_rd_en` is never high with `fifo_empty` = 1. `m_data`/`m_last` are stable on every stall cycle. `occ + pend` ≤ 2 always.
- **Empty boundary:** FIFO empties after 5 words and refills 10 cycles later → `m_valid` drops after word 5. Word 6 appears 2 cycles after `fifo_empty` falls, with `burst_cnt` = 5.
- **Reset mid-burst:** assert `rst` at beat 7 while `pend` = 1 → the in-flight word is discarded. Post-reset beats restart at `burst_cnt` = 0, and `m_last` is high on the 16th beat after reset.
